// File: rtl/mod_mul_interleaved.sv
// Bit-serial interleaved (Blakley) modular multiplier: P = (A * B) mod N.
// Define MODMUL_REDUCE_EN to pre-reduce A mod N; otherwise A >= N is flagged as an error.
module mod_mul_interleaved #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] N,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic             err
);

    localparam int unsigned DW = WIDTH + 2;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef MODMUL_REDUCE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RED_A = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    r_q;
    logic [WIDTH-1:0] ared_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] p_q;
    logic             err_q;
    logic             out_valid_q;
    logic             in_ready_q;
`ifdef MODMUL_REDUCE_EN
    logic [WIDTH-1:0] a_q;
    logic [DW-1:0]    red_t;
    logic [DW-1:0]    red_d;
`endif
    logic [DW-1:0]    n_ext;
    logic [DW-1:0]    n2_ext;
    logic [DW-1:0]    mul_t;
    logic [DW-1:0]    mul_d;
    logic             capture;
    logic             bad_op;

    assign capture = in_valid && in_ready_q && !abort;

`ifdef MODMUL_REDUCE_EN
    assign bad_op = (N == '0);
`else
    assign bad_op = (N == '0) || (A >= N);
`endif

    // Step datapath: with R < N and Ared < N, t = 2R + b*Ared stays below 3N.
    always_comb begin
        n_ext  = {2'b00, n_q};
        n2_ext = {1'b0, n_q, 1'b0};
        mul_t  = (r_q << 1) + (b_q[cnt_q] ? {2'b00, ared_q} : '0);
        if (mul_t >= n2_ext) begin
            mul_d = mul_t - n2_ext;
        end else if (mul_t >= n_ext) begin
            mul_d = mul_t - n_ext;
        end else begin
            mul_d = mul_t;
        end
`ifdef MODMUL_REDUCE_EN
        red_t = (r_q << 1) | DW'(a_q[cnt_q]);
        red_d = (red_t >= n_ext) ? (red_t - n_ext) : red_t;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            ared_q      <= '0;
            b_q         <= '0;
            n_q         <= '0;
            p_q         <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef MODMUL_REDUCE_EN
            a_q         <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (capture) begin
                        b_q        <= B;
                        n_q        <= N;
                        r_q        <= '0;
                        cnt_q      <= CW'(WIDTH - 1);
                        in_ready_q <= 1'b0;
                        if (bad_op) begin
                            state_q     <= S_DONE;
                            p_q         <= '0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
`ifdef MODMUL_REDUCE_EN
                            a_q     <= A;
                            state_q <= S_RED_A;
`else
                            ared_q  <= A;
                            state_q <= S_MUL;
`endif
                        end
                    end
                end
`ifdef MODMUL_REDUCE_EN
                S_RED_A: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else if (cnt_q == '0) begin
                        ared_q  <= red_d[WIDTH-1:0];
                        r_q     <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        state_q <= S_MUL;
                    end else begin
                        r_q   <= red_d;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                S_MUL: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        r_q <= mul_d;
                        if (cnt_q == '0) begin
                            p_q         <= mul_d[WIDTH-1:0];
                            err_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (abort || out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign err       = err_q;

endmodule
